// File: rtl/rmii_rx_frame_aligner_if.sv
// RMII receive path bundle: raw PHY pins in, cleaned nibble-aligned stream and frame flags out.
interface rmii_rx_frame_aligner_if;
    logic [1:0] phy_rxd;
    logic       phy_crsdv;
    logic [1:0] rmii_rxd;
    logic       rmii_crsdv;
    logic       sfd_det;
    logic       frame_end;
    logic       false_carrier;
    logic       jabber;

    modport master (
        input  phy_rxd, phy_crsdv,
        output rmii_rxd, rmii_crsdv, sfd_det, frame_end, false_carrier, jabber
    );

    modport slave (
        output phy_rxd, phy_crsdv,
        input  rmii_rxd, rmii_crsdv, sfd_det, frame_end, false_carrier, jabber
    );
endinterface

// File: rtl/rmii_rx_frame_aligner.sv
// RMII RX front end: strips idle dibits, decodes toggled CRS_DV at frame end and re-emits
// a nibble-aligned dibit stream with a clean data valid, SFD/false-carrier/jabber flags.
module rmii_rx_frame_aligner #(
    parameter int SAMPLE_PHASE = 5,
    parameter int MAX_DIBITS   = 6100,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_50m,
    input  logic                    rst_n,
    input  logic [2:0]              eth_speed,
    input  logic                    cnt_clr,
    rmii_rx_frame_aligner_if.master rx,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [CNT_W-1:0]        fc_cnt
);
    localparam logic [2:0]  SPD_100 = 3'h2;
    localparam logic [2:0]  SPD_10  = 3'h1;
    localparam logic [3:0]  PHASE   = 4'(SAMPLE_PHASE);
    localparam logic [12:0] MAX_D   = 13'(MAX_DIBITS);

    typedef enum logic [2:0] {IDLE, WAIT_PRE, DATA, FALSE_CAR, JABBER} state_t;
    state_t state, state_nx;

    logic [1:0]  in_d, hold_d, pend_lo, pend_hi, out_d, last_out, pend_n;
    logic        in_dv, in_dv_q;
    logic [2:0]  speed_q;
    logic [3:0]  div;
    logic        spd_en, spd_chg, strobe, fall_evt;
    logic        par, par_nx, dv_low, dv_low_nx;
    logic [12:0] dib_cnt, dib_cnt_nx, cnt_inc;
    logic        hold_en, commit, fc_evt, jab_evt;
    logic        sfd_seen, jab_frame;

    assign spd_en   = (eth_speed == SPD_100) || (eth_speed == SPD_10);
    assign strobe   = (eth_speed == SPD_100) || ((eth_speed == SPD_10) && (div == PHASE));
    // Speed change only matters while a frame is in flight or still draining
    assign spd_chg  = (eth_speed != speed_q) &&
                      ((state != IDLE) || (pend_n != 2'd0) || rx.rmii_crsdv);
    assign cnt_inc  = dib_cnt + 13'd2;
    assign out_d    = (pend_n == 2'd2) ? pend_lo : pend_hi;
    assign fall_evt = strobe && !spd_chg && (pend_n == 2'd0) && rx.rmii_crsdv;

    // Input register stage and 10M dibit-phase divider
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            in_d    <= '0;
            in_dv   <= 1'b0;
            in_dv_q <= 1'b0;
            speed_q <= '0;
            div     <= '0;
        end else begin
            in_d    <= rx.phy_rxd;
            in_dv   <= rx.phy_crsdv;
            in_dv_q <= in_dv;
            speed_q <= eth_speed;
            if ((state == IDLE) && in_dv && !in_dv_q)
                div <= '0;
            else if (div == 4'd9)
                div <= '0;
            else
                div <= div + 4'd1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            par     <= 1'b0;
            dv_low  <= 1'b0;
            dib_cnt <= '0;
        end else begin
            state   <= state_nx;
            par     <= par_nx;
            dv_low  <= dv_low_nx;
            dib_cnt <= dib_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        par_nx     = par;
        dv_low_nx  = dv_low;
        dib_cnt_nx = dib_cnt;
        hold_en    = 1'b0;
        commit     = 1'b0;
        fc_evt     = 1'b0;
        jab_evt    = 1'b0;
        if (spd_chg) begin
            state_nx   = IDLE;
            par_nx     = 1'b0;
            dv_low_nx  = 1'b0;
            dib_cnt_nx = '0;
        end else if (strobe) begin
            unique case (state)
                IDLE: if (in_dv) state_nx = WAIT_PRE;
                WAIT_PRE: begin
                    if (!in_dv) begin
                        state_nx = IDLE;
                    end else if (in_d == 2'b01) begin
                        // The first 01 is the low dibit of the first nibble
                        state_nx   = DATA;
                        hold_en    = 1'b1;
                        par_nx     = 1'b1;
                        dib_cnt_nx = '0;
                    end else if (in_d == 2'b10) begin
                        state_nx  = FALSE_CAR;
                        fc_evt    = 1'b1;
                        dv_low_nx = 1'b0;
                    end
                end
                DATA: begin
                    par_nx = ~par;
                    if (!par) begin
                        hold_en = 1'b1;
                    end else if (!in_dv) begin
                        state_nx = IDLE;
                    end else begin
                        commit     = 1'b1;
                        dib_cnt_nx = cnt_inc;
                        if (cnt_inc >= MAX_D) begin
                            jab_evt   = 1'b1;
                            state_nx  = JABBER;
                            dv_low_nx = 1'b0;
                        end
                    end
                end
                FALSE_CAR, JABBER: begin
                    if (in_dv) begin
                        dv_low_nx = 1'b0;
                    end else if (dv_low) begin
                        state_nx  = IDLE;
                        dv_low_nx = 1'b0;
                    end else begin
                        dv_low_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (hold_en) hold_d <= in_d;
        if (commit) begin
            pend_lo <= hold_d;
            pend_hi <= in_d;
        end
    end

    // Output stage: two-slot nibble buffer drained one dibit per strobe
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx.rmii_rxd      <= '0;
            rx.rmii_crsdv    <= 1'b0;
            rx.sfd_det       <= 1'b0;
            rx.frame_end     <= 1'b0;
            rx.false_carrier <= 1'b0;
            rx.jabber        <= 1'b0;
            pend_n           <= '0;
            last_out         <= '0;
            sfd_seen         <= 1'b0;
            jab_frame        <= 1'b0;
        end else begin
            rx.sfd_det       <= 1'b0;
            rx.frame_end     <= 1'b0;
            rx.jabber        <= 1'b0;
            rx.false_carrier <= fc_evt;
            if (spd_chg || !spd_en) begin
                rx.rmii_rxd   <= '0;
                rx.rmii_crsdv <= 1'b0;
                pend_n        <= '0;
                last_out      <= '0;
                sfd_seen      <= 1'b0;
                jab_frame     <= 1'b0;
            end else begin
                if (jab_evt) jab_frame <= 1'b1;
                if (strobe) begin
                    if (pend_n != 2'd0) begin
                        rx.rmii_rxd   <= out_d;
                        rx.rmii_crsdv <= 1'b1;
                        last_out      <= out_d;
                        pend_n        <= pend_n - 2'd1;
                        if ((out_d == 2'b11) && (last_out == 2'b01) && !sfd_seen) begin
                            rx.sfd_det <= 1'b1;
                            sfd_seen   <= 1'b1;
                        end
                    end else begin
                        rx.rmii_rxd   <= '0;
                        rx.rmii_crsdv <= 1'b0;
                        last_out      <= '0;
                        sfd_seen      <= 1'b0;
                        if (fall_evt) begin
                            rx.frame_end <= 1'b1;
                            rx.jabber    <= jab_frame;
                            jab_frame    <= 1'b0;
                        end
                    end
                    if (commit) pend_n <= 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            fc_cnt    <= '0;
        end else begin
            if (cnt_clr)
                frame_cnt <= '0;
            else if (fall_evt && !jab_frame && (frame_cnt != '1))
                frame_cnt <= frame_cnt + 1'b1;
            if (cnt_clr)
                fc_cnt <= '0;
            else if (fc_evt && (fc_cnt != '1))
                fc_cnt <= fc_cnt + 1'b1;
        end
    end
endmodule
